// File: rtl/rotor_stage_pkg.sv
// Shared constants for the rotor stage: default alphabet geometry,
// traversal direction encoding and the invalid-letter code.
package rotor_stage_pkg;

  localparam int unsigned ALPHA_DEF = 26;
  localparam int unsigned W_DEF     = 5;

  // in_dir encoding: right-to-left uses fwd, left-to-right uses inv
  localparam logic DIR_R2L = 1'b0;
  localparam logic DIR_L2R = 1'b1;

  // Letter code returned for out-of-alphabet inputs (all ones)
  localparam logic [W_DEF-1:0] LETTER_INVALID = '1;

endpackage

// File: rtl/rotor_stage_mod_addsub.sv
// Combinational W-bit add/subtract modulo ALPHA; operands assumed < ALPHA.
module mod_addsub #(
  parameter int unsigned ALPHA = 26,
  parameter int unsigned W     = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum_c
);

  localparam logic [W:0] MOD = (W+1)'(ALPHA);

  logic [W:0] a_x;
  logic [W:0] b_x;
  logic [W:0] raw;

  // One widened add/sub followed by a single conditional correction
  always_comb begin
    a_x   = {1'b0, a};
    b_x   = {1'b0, b};
    raw   = '0;
    sum_c = '0;
    if (sub) begin
      raw   = a_x - b_x;
      sum_c = (a_x < b_x) ? W'(raw + MOD) : W'(raw);
    end else begin
      raw   = a_x + b_x;
      sum_c = (raw >= MOD) ? W'(raw - MOD) : W'(raw);
    end
  end

endmodule

// File: rtl/rotor_stage.sv
// Single rotor: programmable wiring with inverse table, ring offset,
// stepping position with turnover carry, and a one-cycle lookup pipe.
module rotor_stage
  import rotor_stage_pkg::*;
#(
  parameter int unsigned ALPHA = ALPHA_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic [W-1:0] ring,
  input  logic [W-1:0] notch,
  input  logic         set_pos,
  input  logic [W-1:0] pos_in,
  input  logic         step_in,
  output logic [W-1:0] pos,
  output logic         turnover,
  input  logic         in_valid,
  input  logic         in_dir,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  localparam logic [W:0]   ALPHA_X = (W+1)'(ALPHA);
  localparam logic [W-1:0] LAST    = W'(ALPHA - 1);
  localparam logic [W-1:0] INVALID = (W == W_DEF) ? W'(LETTER_INVALID) : {W{1'b1}};

  logic [W-1:0] fwd [ALPHA];
  logic [W-1:0] inv [ALPHA];

  logic         letter_ok_c;
  logic         cfg_ok_c;
  logic [W-1:0] letter_c;
  logic [W-1:0] dp_c;
  logic [W-1:0] e_c;
  logic [W-1:0] t_c;
  logic [W-1:0] tp_c;
  logic [W-1:0] res_c;
  logic [W-1:0] pos_load_c;
  logic [W:0]   pos_in_x;

  // Input qualification, table read and position-load reduction
  always_comb begin
    letter_ok_c = ({1'b0, in_data} < ALPHA_X);
    cfg_ok_c    = cfg_we && ({1'b0, cfg_addr} < ALPHA_X) && ({1'b0, cfg_data} < ALPHA_X);
    letter_c    = letter_ok_c ? in_data : '0;
    t_c         = (in_dir == DIR_L2R) ? inv[e_c] : fwd[e_c];
    pos_in_x    = {1'b0, pos_in};
    pos_load_c  = (pos_in_x >= ALPHA_X) ? W'(pos_in_x - ALPHA_X) : pos_in;
  end

  // Entry offset: e = in_data + pos - ring
  mod_addsub #(.ALPHA(ALPHA), .W(W)) u_entry_add (
    .a(letter_c), .b(pos), .sub(1'b0), .sum_c(dp_c)
  );
  mod_addsub #(.ALPHA(ALPHA), .W(W)) u_entry_sub (
    .a(dp_c), .b(ring), .sub(1'b1), .sum_c(e_c)
  );

  // Exit offset: out = t - pos + ring
  mod_addsub #(.ALPHA(ALPHA), .W(W)) u_exit_sub (
    .a(t_c), .b(pos), .sub(1'b1), .sum_c(tp_c)
  );
  mod_addsub #(.ALPHA(ALPHA), .W(W)) u_exit_add (
    .a(tp_c), .b(ring), .sub(1'b0), .sum_c(res_c)
  );

  // Wiring tables: identity on reset, paired forward/inverse writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ALPHA; i++) begin
        fwd[i] <= W'(i);
        inv[i] <= W'(i);
      end
    end else if (cfg_ok_c) begin
      fwd[cfg_addr] <= cfg_data;
      inv[cfg_data] <= cfg_addr;
    end
  end

  // Position register with load-over-step priority and turnover carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos      <= '0;
      turnover <= 1'b0;
    end else begin
      turnover <= 1'b0;
      if (set_pos) begin
        pos <= pos_load_c;
      end else if (step_in) begin
        pos      <= (pos == LAST) ? '0 : W'(pos + W'(1));
        turnover <= (pos == notch);
      end
    end
  end

  // Lookup result register; data holds while no input is valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= letter_ok_c ? res_c : INVALID;
      end
    end
  end

endmodule

// File: doc/rotor_stage.md
ROTOR_STAGE -- requirements
Module: rotor_stage

Interface
REQ-001 The module SHALL have parameter ALPHA, default 26: alphabet size, letters 0..ALPHA-1.
REQ-002 The module SHALL have parameter W, default 5: letter width in bits, with 2^W > ALPHA required.
REQ-003 The module SHALL have port clk  input  1: single clock, rising edge.
REQ-004 The module SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 The module SHALL have port cfg_we  input  1: wiring-table write strobe.
REQ-006 The module SHALL have ports cfg_addr, cfg_data  input  W each: right-contact index and left-contact value.
REQ-007 The module SHALL have ports ring  input  W and notch  input  W: ring setting and turnover letter, both static during use.
REQ-008 The module SHALL have ports set_pos  input  1 and pos_in  input  W: synchronous position load.
REQ-009 The module SHALL have port step_in  input  1: advance position by one.
REQ-010 The module SHALL have port pos  output  W: current rotor position.
REQ-011 The module SHALL have port turnover  output  1: registered one-cycle carry to the next rotor.
REQ-012 The module SHALL have ports in_valid  input  1, in_dir  input  1 (0 = right-to-left, 1 = left-to-right) and in_data  input  W.
REQ-013 The module SHALL have ports out_valid  output  1 and out_data  output  W.

Function
REQ-014 The module SHALL hold a forward table fwd[ALPHA] and an inverse table inv[ALPHA], each W bits per entry.
REQ-015 A cycle with cfg_we=1 and cfg_addr<ALPHA SHALL write fwd[cfg_addr]=cfg_data and inv[cfg_data]=cfg_addr in that same edge.
REQ-016 A write with cfg_addr or cfg_data >= ALPHA SHALL be ignored.
REQ-017 Position update SHALL follow this priority: set_pos loads pos_in mod ALPHA; else step_in does pos=(pos+1) mod ALPHA, wrapping ALPHA-1 -> 0; else pos holds.
REQ-018 turnover SHALL be 1 in the cycle after a step_in-driven update from pos==notch; set_pos SHALL never assert turnover.
REQ-019 Lookup SHALL compute e=(in_data+pos-ring) mod ALPHA and t=fwd[e] (in_dir=0) or inv[e] (in_dir=1).
REQ-020 The lookup result SHALL be out_data=(t-pos+ring) mod ALPHA, using pos as registered before any same-cycle step/set.
REQ-021 Modular arithmetic SHALL use W+1-bit intermediates with a single conditional add/subtract of ALPHA; no divider.
REQ-022 out_valid and out_data SHALL be registered with latency exactly 1 cycle after in_valid; back-to-back valid inputs SHALL be accepted every cycle, with no backpressure.
REQ-023 in_valid with in_data >= ALPHA SHALL produce out_valid=1 with out_data = all ones (2^W-1).
REQ-024 A lookup in the same cycle as cfg_we SHALL read the table contents before the write.
REQ-025 out_data SHALL hold its last value while out_valid=0.

Reset
REQ-026 On rst, out_valid, turnover and pos SHALL be 0, out_data SHALL be 0, and fwd[i]=inv[i]=i (identity, transparent rotor).
REQ-027 Reset asserted mid-operation SHALL discard any in-flight lookup, with no out_valid after deassertion.

Structure
REQ-028 A shared package SHALL hold ALPHA/W defaults, the in_dir encoding constants and the invalid-letter code (all ones).
REQ-029 One sub-module, mod_addsub (W-bit modular add/subtract mod ALPHA), SHALL be instantiated for the e and out_data computations.

Verification
REQ-030 Load rotor I wiring (4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9), ring=0, pos=0: fwd in 0 -> out 4 one cycle later; rev in 4 -> out 0.
REQ-031 Same wiring, pos=1, ring=0: fwd in 0 -> 9; ring=1, pos=0: fwd in 0 -> 10.
REQ-032 notch=16, set pos=15, two step_in pulses: pos 16 then 17, turnover=1 for exactly one cycle after the second step; step from 25 -> pos 0, no turnover.
REQ-033 Streaming: 26 consecutive valid fwd inputs 0..25 with identity tables, pos=3: out_valid high 26 cycles; each output equals its input.
REQ-034 in_data=27 -> out_data=31; cfg write with cfg_addr=26 -> tables unchanged.
REQ-035 Assert rst while in_valid=1: out_valid=0, pos=0, tables identity after release.
